// File: rtl/tia_biphase_rx.sv
`timescale 1ns/1ps
// tia_biphase_rx
//   Receiver for the TIA two-phase (s1/s2) clock interface. Samples both
//   phases on clk, emits single-clk strobes on accepted rising edges, measures
//   the s1->s1 period to declare lock, counts completed s1->s2 cycles and
//   raises sticky protocol error flags.
// Ports
//   clk          master clock, all state on posedge
//   rstl         asynchronous active-low reset
//   s1, s2       phase inputs, synchronous to clk
//   clr_err      one-clk pulse, clears sticky error flags
//   s1_stb       pulse: s1 rising edge accepted
//   s2_stb       pulse: s2 rising edge accepted
//   locked       phase sequence and period stable
//   cycle_count  completed s1->s2 cycles, wraps at 2^CW
//   err_overlap  sticky: s1 and s2 high in the same sample
//   err_order    sticky: a phase rose out of sequence
//   err_timeout  sticky: no phase edge for TIMEOUT clks
module tia_biphase_rx #(
  parameter int PERIOD  = 4,
  parameter int LOCK_N  = 3,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rstl,
  input  logic          s1,
  input  logic          s2,
  input  logic          clr_err,
  output logic          s1_stb,
  output logic          s2_stb,
  output logic          locked,
  output logic [CW-1:0] cycle_count,
  output logic          err_overlap,
  output logic          err_order,
  output logic          err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {WAIT_S1, IN_S1, WAIT_S2, IN_S2} state_t;

  state_t        state, state_nxt, state_eff;
  logic          s1_q, s2_q;
  logic [TW-1:0] per_cnt, per_nxt;
  logic [TW-1:0] idle_cnt, idle_nxt;
  logic [GW-1:0] good_cnt, good_nxt;

  logic s1_rise, s2_rise, any_edge, overlap;
  logic s1_acc, s2_acc, order_evt, cyc_inc, lock_clr, timeout_evt;

  always_comb begin
    s1_rise  = s1 & ~s1_q;
    s2_rise  = s2 & ~s2_q;
    any_edge = (s1 ^ s1_q) | (s2 ^ s2_q);
    overlap  = s1 & s2;

    // Falls are applied before rises so that a phase hand-over in a single
    // sample (s1 falling while s2 rises) is seen as in sequence.
    state_eff = state;
    if (state == IN_S1 && !s1) state_eff = WAIT_S2;
    if (state == IN_S2 && !s2) state_eff = WAIT_S1;

    state_nxt = state;
    s1_acc    = 1'b0;
    s2_acc    = 1'b0;
    order_evt = 1'b0;
    cyc_inc   = 1'b0;
    lock_clr  = 1'b0;

    if (overlap) begin
      lock_clr = 1'b1;
    end else begin
      state_nxt = state_eff;
      if (s1_rise) begin
        s1_acc    = 1'b1;
        state_nxt = IN_S1;
        if (state_eff != WAIT_S1) begin
          order_evt = 1'b1;
          lock_clr  = 1'b1;
        end
      end else if (s2_rise) begin
        s2_acc    = 1'b1;
        state_nxt = IN_S2;
        if (state_eff != WAIT_S2) begin
          order_evt = 1'b1;
          lock_clr  = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
    end

    // Idle counter holds at TIMEOUT so the timeout event fires only once.
    timeout_evt = 1'b0;
    if (any_edge) begin
      idle_nxt = '0;
    end else if (idle_cnt != TW'(TIMEOUT)) begin
      idle_nxt = idle_cnt + 1'b1;
      if (idle_cnt == TW'(TIMEOUT - 1)) timeout_evt = 1'b1;
    end else begin
      idle_nxt = idle_cnt;
    end
    if (timeout_evt) begin
      state_nxt = WAIT_S1;
      lock_clr  = 1'b1;
    end

    // Period since the last accepted s1 rise; a value of 0 means no
    // previous rise, which never matches PERIOD.
    good_nxt = good_cnt;
    if (s1_acc) begin
      per_nxt = TW'(1);
      if (!order_evt) begin
        if (per_cnt == TW'(PERIOD)) begin
          if (good_cnt != GW'(LOCK_N)) good_nxt = good_cnt + 1'b1;
        end else begin
          good_nxt = '0;
        end
      end
    end else if (per_cnt != TW'(TIMEOUT)) begin
      per_nxt = per_cnt + 1'b1;
    end else begin
      per_nxt = per_cnt;
    end
    if (lock_clr) good_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state       <= WAIT_S1;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      per_cnt     <= '0;
      idle_cnt    <= '0;
      good_cnt    <= '0;
      s1_stb      <= 1'b0;
      s2_stb      <= 1'b0;
      locked      <= 1'b0;
      cycle_count <= '0;
      err_overlap <= 1'b0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      s1_q        <= s1;
      s2_q        <= s2;
      per_cnt     <= per_nxt;
      idle_cnt    <= idle_nxt;
      good_cnt    <= good_nxt;
      s1_stb      <= s1_acc;
      s2_stb      <= s2_acc;
      locked      <= (good_nxt == GW'(LOCK_N));
      if (cyc_inc) cycle_count <= cycle_count + 1'b1;
      err_overlap <= (err_overlap & ~clr_err) | overlap;
      err_order   <= (err_order   & ~clr_err) | order_evt;
      err_timeout <= (err_timeout & ~clr_err) | timeout_evt;
    end
  end

endmodule

// File: tb/tb_tia_biphase_rx.sv
`timescale 1ns/1ps
module tb_tia_biphase_rx;

  logic       clk = 1'b0;
  logic       rstl;
  logic       s1, s2, clr_err;
  logic       s1_stb, s2_stb, locked, err_overlap, err_order, err_timeout;
  logic [7:0] cycle_count;
  logic       s1_stb2, s2_stb2, locked2, err_overlap2, err_order2, err_timeout2;
  logic [1:0] cycle_count2;

  always #5 clk = ~clk;

  tia_biphase_rx #(.PERIOD(4), .LOCK_N(3), .TIMEOUT(16), .CW(8)) dut (
    .clk(clk), .rstl(rstl), .s1(s1), .s2(s2), .clr_err(clr_err),
    .s1_stb(s1_stb), .s2_stb(s2_stb), .locked(locked),
    .cycle_count(cycle_count), .err_overlap(err_overlap),
    .err_order(err_order), .err_timeout(err_timeout)
  );

  tia_biphase_rx #(.PERIOD(4), .LOCK_N(3), .TIMEOUT(16), .CW(2)) dut2 (
    .clk(clk), .rstl(rstl), .s1(s1), .s2(s2), .clr_err(clr_err),
    .s1_stb(s1_stb2), .s2_stb(s2_stb2), .locked(locked2),
    .cycle_count(cycle_count2), .err_overlap(err_overlap2),
    .err_order(err_order2), .err_timeout(err_timeout2)
  );

  typedef struct packed {
    logic       s1_stb;
    logic       s2_stb;
    logic       locked;
    logic [7:0] cnt;
    logic       ov;
    logic       ord;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [7:0] e_cnt;
  logic       e_lock, e_ov, e_or, e_to;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic push_exp(input logic es1, input logic es2);
    exp_t e;
    e.s1_stb = es1;
    e.s2_stb = es2;
    e.locked = e_lock;
    e.cnt    = e_cnt;
    e.ov     = e_ov;
    e.ord    = e_or;
    e.to     = e_to;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL sb_empty observed=0 expected=1");
      end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp("s1_stb",       8'(s1_stb),       8'(e.s1_stb));
      cmp("s2_stb",       8'(s2_stb),       8'(e.s2_stb));
      cmp("locked",       8'(locked),       8'(e.locked));
      cmp("cycle_count",  cycle_count,      e.cnt);
      cmp("err_overlap",  8'(err_overlap),  8'(e.ov));
      cmp("err_order",    8'(err_order),    8'(e.ord));
      cmp("err_timeout",  8'(err_timeout),  8'(e.to));
      cmp("cycle_count2", 8'(cycle_count2), 8'(e.cnt[1:0]));
      cmp("locked2",      8'(locked2),      8'(e.locked));
    end
  endtask

  // One sample: drive on negedge, expectation queued, compared after posedge.
  task automatic step(input logic a, input logic b, input logic c,
                      input logic es1, input logic es2);
    @(negedge clk);
    s1 = a;
    s2 = b;
    clr_err = c;
    push_exp(es1, es2);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Nominal 4-clk cycle: s1 high 1 clk, s2 high 1 clk, two idle clks.
  task automatic nom(input logic lk, input logic clr_last);
    e_lock = lk;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    e_cnt = e_cnt + 8'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (clr_last) begin
      e_ov = 1'b0;
      e_or = 1'b0;
      e_to = 1'b0;
    end
    step(1'b0, 1'b0, clr_last, 1'b0, 1'b0);
  endtask

  initial begin
    rstl = 1'b0; s1 = 1'b0; s2 = 1'b0; clr_err = 1'b0;
    e_cnt = '0; e_lock = 1'b0; e_ov = 1'b0; e_or = 1'b0; e_to = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, 1'b0);
    check_out();
    @(negedge clk);
    rstl = 1'b1;

    // Nominal: lock after the 4th s1 rise, count 1..5 (CW=2 copy 1,2,3,0,1)
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b1, 1'b0);
    nom(1'b1, 1'b0);

    // Overlap while locked: no strobe, lock drops, flag clears on clr_err
    e_ov = 1'b1; e_lock = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e_ov = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Overlap in the same clk as clr_err: the error wins
    e_ov = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    e_ov = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Relock: first period is long, then three good ones
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b1, 1'b0);

    // Order: second s1 rise without s2 in between
    e_lock = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_or = 1'b1; e_lock = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    e_cnt = e_cnt + 8'd1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b1, 1'b1);

    // Period drift: one 5-clk period drops lock, then three good periods
    nom(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);
    nom(1'b1, 1'b0);

    // Timeout: last edge is the s2 fall; error on the 16th clk after it
    for (int unsigned i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_to = 1'b1; e_lock = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // FSM back in WAIT_S1: next s1 rise is in sequence
    nom(1'b0, 1'b1);

    // Reset while in IN_S1: outputs clear at once
    e_lock = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rstl = 1'b0;
    #1;
    e_cnt = '0; e_lock = 1'b0; e_ov = 1'b0; e_or = 1'b0; e_to = 1'b0;
    push_exp(1'b0, 1'b0);
    check_out();
    @(negedge clk);
    s1 = 1'b0;
    rstl = 1'b1;
    nom(1'b0, 1'b0);
    nom(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
